// File: rtl/ldst_control_seq.sv
// Control-step sequencer for fetch plus ld/ldi/st/addi with memory-ready wait states.
// Optional memory timeout to a sticky FAULT state is enabled by defining SEQ_MEM_TIMEOUT_EN.
module ldst_control_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output logic       IncPC,
  output logic       PCin,
  output logic       MARin,
  output logic       Read,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Gra,
  output logic       Grb,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       Yin,
  output logic       Cout,
  output logic       ADD,
  output logic       Zin,
  output logic       Zlowout,
  output logic       write_mem,
  output logic       busy,
  output logic [2:0] step,
  output logic       done,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE, S_FAULT
  } state_t;

  localparam logic [1:0] OP_LD   = 2'b00;
  localparam logic [1:0] OP_ST   = 2'b10;
  localparam logic [1:0] OP_ADDI = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] op_q;
  logic       wait_st;
  logic       mem_op;

  // An undersized wait counter would make the timeout compare unreachable.
  if (MEM_TIMEOUT >= (1 << TMO_W)) begin : g_bad_tmo_cfg
  end

  assign mem_op  = (op_q == OP_LD) || (op_q == OP_ST);
  assign wait_st = (state_q == S_T1) ||
                   ((state_q == S_T6) && (op_q == OP_LD)) ||
                   ((state_q == S_T7) && (op_q == OP_ST));

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

  logic [TMO_W-1:0] wait_cnt_q;
  logic             tmo_hit;

  assign tmo_hit = wait_st && !mem_ready && (wait_cnt_q == TMO_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_d != state_q) begin
      wait_cnt_q <= '0;
    end else if (wait_st && !mem_ready && (wait_cnt_q != TMO_MAX)) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
        op_q <= op;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_ready) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = mem_op ? S_T6 : S_DONE;
      S_T6:    if (mem_ready || (op_q != OP_LD)) state_d = S_T7;
      S_T7:    if (mem_ready || (op_q != OP_ST)) state_d = S_DONE;
      S_DONE:  state_d = start ? S_T0 : S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
`ifdef SEQ_MEM_TIMEOUT_EN
    if (tmo_hit) state_d = S_FAULT;
`endif
  end

  always_comb begin
    IncPC     = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    Yin       = 1'b0;
    Cout      = 1'b0;
    ADD       = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    write_mem = 1'b0;
    step      = 3'd0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_T0: begin
        IncPC = 1'b1; PCin = 1'b1; MARin = 1'b1;
        busy  = 1'b1; step = 3'd0;
      end
      S_T1: begin
        Read = 1'b1; MDRin = 1'b1;
        busy = 1'b1; step  = 3'd1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        busy   = 1'b1; step = 3'd2;
      end
      S_T3: begin
        Grb   = 1'b1; Yin = 1'b1;
        Rout  = (op_q == OP_ADDI);
        BAout = (op_q != OP_ADDI);
        busy  = 1'b1; step = 3'd3;
      end
      S_T4: begin
        Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
        busy = 1'b1; step = 3'd4;
      end
      S_T5: begin
        Zlowout = 1'b1;
        MARin   = mem_op;
        Gra     = !mem_op;
        Rin     = !mem_op;
        busy    = 1'b1; step = 3'd5;
      end
      S_T6: begin
        Read  = (op_q == OP_LD);
        Gra   = (op_q != OP_LD);
        Rout  = (op_q != OP_LD);
        MDRin = 1'b1;
        busy  = 1'b1; step = 3'd6;
      end
      S_T7: begin
        MDRout    = (op_q == OP_LD);
        Gra       = (op_q == OP_LD);
        Rin       = (op_q == OP_LD);
        write_mem = (op_q != OP_LD);
        busy      = 1'b1; step = 3'd7;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  assign fault = (state_q == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_ldst_control_seq.sv
// Directed vector bench for ldst_control_seq: per-cycle table plus wait/timeout sequences.
module tb_ldst_control_seq;

  logic       clk = 1'b0;
  logic       reset, start, mem_ready;
  logic [1:0] op;
  logic IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Gra, Grb, Rin, Rout, BAout;
  logic Yin, Cout, ADD, Zin, Zlowout, write_mem, busy, done, fault;
  logic [2:0] step;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ldst_control_seq #(.MEM_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .mem_ready(mem_ready),
    .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Yin(Yin), .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout),
    .write_mem(write_mem), .busy(busy), .step(step), .done(done), .fault(fault)
  );

  localparam logic [17:0] B_INCPC = 18'b1 << 17;
  localparam logic [17:0] B_PCIN  = 18'b1 << 16;
  localparam logic [17:0] B_MARIN = 18'b1 << 15;
  localparam logic [17:0] B_READ  = 18'b1 << 14;
  localparam logic [17:0] B_MDRIN = 18'b1 << 13;
  localparam logic [17:0] B_MDROUT= 18'b1 << 12;
  localparam logic [17:0] B_IRIN  = 18'b1 << 11;
  localparam logic [17:0] B_GRA   = 18'b1 << 10;
  localparam logic [17:0] B_GRB   = 18'b1 << 9;
  localparam logic [17:0] B_RIN   = 18'b1 << 8;
  localparam logic [17:0] B_ROUT  = 18'b1 << 7;
  localparam logic [17:0] B_BAOUT = 18'b1 << 6;
  localparam logic [17:0] B_YIN   = 18'b1 << 5;
  localparam logic [17:0] B_COUT  = 18'b1 << 4;
  localparam logic [17:0] B_ADD   = 18'b1 << 3;
  localparam logic [17:0] B_ZIN   = 18'b1 << 2;
  localparam logic [17:0] B_ZLOW  = 18'b1 << 1;
  localparam logic [17:0] B_WRITE = 18'b1;

  localparam logic [17:0] E_NONE = 18'b0;
  localparam logic [17:0] E_T0   = B_INCPC | B_PCIN | B_MARIN;
  localparam logic [17:0] E_T1   = B_READ | B_MDRIN;
  localparam logic [17:0] E_T2   = B_MDROUT | B_IRIN;
  localparam logic [17:0] E_T3B  = B_GRB | B_YIN | B_BAOUT;
  localparam logic [17:0] E_T3R  = B_GRB | B_YIN | B_ROUT;
  localparam logic [17:0] E_T4   = B_COUT | B_ADD | B_ZIN;
  localparam logic [17:0] E_T5I  = B_ZLOW | B_GRA | B_RIN;
  localparam logic [17:0] E_T5M  = B_ZLOW | B_MARIN;
  localparam logic [17:0] E_T6L  = B_READ | B_MDRIN;
  localparam logic [17:0] E_T6S  = B_GRA | B_ROUT | B_MDRIN;
  localparam logic [17:0] E_T7L  = B_MDROUT | B_GRA | B_RIN;
  localparam logic [17:0] E_T7S  = B_WRITE;

  logic [23:0] obs;
  assign obs = {IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Gra, Grb, Rin, Rout,
                BAout, Yin, Cout, ADD, Zin, Zlowout, write_mem, step, busy, done, fault};

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        mr;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic st, input logic [1:0] o,
                              input logic mr, input logic [17:0] s, input logic [2:0] stp,
                              input logic b, input logic d, input logic f);
    vec_t v;
    v.rst = rst; v.start = st; v.op = o; v.mr = mr;
    v.exp = {s, stp, b, d, f};
    tbl.push_back(v);
  endfunction

  // Called at a negedge: check the current state's outputs, then drive inputs for the next edge.
  task automatic cyc(input string tag, input logic rst, input logic st, input logic [1:0] o,
                     input logic mr, input logic [23:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b want %b", tag, obs, exp);
    end
    reset = rst; start = st; op = o; mem_ready = mr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; mem_ready = 1'b0;

    // ldi with op changing after acceptance and mem_ready low outside wait states
    add(0,1,2'b01,1, E_NONE,3'd0,0,0,0);
    add(0,0,2'b11,1, E_T0  ,3'd0,1,0,0);
    add(0,0,2'b11,1, E_T1  ,3'd1,1,0,0);
    add(0,0,2'b11,0, E_T2  ,3'd2,1,0,0);
    add(0,0,2'b11,0, E_T3B ,3'd3,1,0,0);
    add(0,0,2'b11,1, E_T4  ,3'd4,1,0,0);
    add(0,0,2'b11,1, E_T5I ,3'd5,1,0,0);
    add(0,0,2'b01,1, E_NONE,3'd0,0,1,0);
    add(0,0,2'b00,1, E_NONE,3'd0,0,0,0);
    // st with 3 wait cycles in T7
    add(0,1,2'b10,1, E_NONE,3'd0,0,0,0);
    add(0,0,2'b00,0, E_T0  ,3'd0,1,0,0);
    add(0,0,2'b00,1, E_T1  ,3'd1,1,0,0);
    add(0,0,2'b00,1, E_T2  ,3'd2,1,0,0);
    add(0,0,2'b00,1, E_T3B ,3'd3,1,0,0);
    add(0,0,2'b00,1, E_T4  ,3'd4,1,0,0);
    add(0,0,2'b00,1, E_T5M ,3'd5,1,0,0);
    add(0,0,2'b00,0, E_T6S ,3'd6,1,0,0);
    add(0,0,2'b00,0, E_T7S ,3'd7,1,0,0);
    add(0,0,2'b00,0, E_T7S ,3'd7,1,0,0);
    add(0,0,2'b00,0, E_T7S ,3'd7,1,0,0);
    add(0,0,2'b00,1, E_T7S ,3'd7,1,0,0);
    add(0,0,2'b00,1, E_NONE,3'd0,0,1,0);
    add(0,0,2'b00,1, E_NONE,3'd0,0,0,0);
    // ld with 2 waits in T1 and 1 in T6; start while busy ignored
    add(0,1,2'b00,1, E_NONE,3'd0,0,0,0);
    add(0,1,2'b11,1, E_T0  ,3'd0,1,0,0);
    add(0,0,2'b11,0, E_T1  ,3'd1,1,0,0);
    add(0,0,2'b11,0, E_T1  ,3'd1,1,0,0);
    add(0,1,2'b11,1, E_T1  ,3'd1,1,0,0);
    add(0,0,2'b11,1, E_T2  ,3'd2,1,0,0);
    add(0,0,2'b11,1, E_T3B ,3'd3,1,0,0);
    add(0,0,2'b11,1, E_T4  ,3'd4,1,0,0);
    add(0,0,2'b11,1, E_T5M ,3'd5,1,0,0);
    add(0,0,2'b11,0, E_T6L ,3'd6,1,0,0);
    add(0,0,2'b11,1, E_T6L ,3'd6,1,0,0);
    add(0,0,2'b11,0, E_T7L ,3'd7,1,0,0);
    add(0,0,2'b11,1, E_NONE,3'd0,0,1,0);
    add(0,0,2'b11,1, E_NONE,3'd0,0,0,0);
    // addi then ldi back-to-back with start held
    add(0,1,2'b11,1, E_NONE,3'd0,0,0,0);
    add(0,1,2'b01,1, E_T0  ,3'd0,1,0,0);
    add(0,1,2'b01,1, E_T1  ,3'd1,1,0,0);
    add(0,1,2'b01,1, E_T2  ,3'd2,1,0,0);
    add(0,1,2'b01,1, E_T3R ,3'd3,1,0,0);
    add(0,1,2'b01,1, E_T4  ,3'd4,1,0,0);
    add(0,1,2'b01,1, E_T5I ,3'd5,1,0,0);
    add(0,1,2'b01,1, E_NONE,3'd0,0,1,0);
    add(0,1,2'b01,1, E_T0  ,3'd0,1,0,0);
    add(0,1,2'b01,1, E_T1  ,3'd1,1,0,0);
    add(0,1,2'b01,1, E_T2  ,3'd2,1,0,0);
    add(0,1,2'b01,1, E_T3B ,3'd3,1,0,0);
    add(0,1,2'b01,1, E_T4  ,3'd4,1,0,0);
    add(0,1,2'b01,1, E_T5I ,3'd5,1,0,0);
    add(0,0,2'b01,1, E_NONE,3'd0,0,1,0);
    add(0,0,2'b01,1, E_NONE,3'd0,0,0,0);
    // reset during ld-T6, then a clean ldi
    add(0,1,2'b00,1, E_NONE,3'd0,0,0,0);
    add(0,0,2'b00,1, E_T0  ,3'd0,1,0,0);
    add(0,0,2'b00,1, E_T1  ,3'd1,1,0,0);
    add(0,0,2'b00,1, E_T2  ,3'd2,1,0,0);
    add(0,0,2'b00,1, E_T3B ,3'd3,1,0,0);
    add(0,0,2'b00,1, E_T4  ,3'd4,1,0,0);
    add(0,0,2'b00,1, E_T5M ,3'd5,1,0,0);
    add(1,0,2'b00,0, E_T6L ,3'd6,1,0,0);
    add(0,1,2'b01,1, E_NONE,3'd0,0,0,0);
    add(0,0,2'b01,1, E_T0  ,3'd0,1,0,0);
    add(0,0,2'b01,1, E_T1  ,3'd1,1,0,0);
    add(0,0,2'b01,1, E_T2  ,3'd2,1,0,0);
    add(0,0,2'b01,1, E_T3B ,3'd3,1,0,0);
    add(0,0,2'b01,1, E_T4  ,3'd4,1,0,0);
    add(0,0,2'b01,1, E_T5I ,3'd5,1,0,0);
    add(0,0,2'b01,1, E_NONE,3'd0,0,1,0);

    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      cyc($sformatf("tbl[%0d]", i), tbl[i].rst, tbl[i].start, tbl[i].op, tbl[i].mr, tbl[i].exp);
    end

    // 15-cycle wait in T1, then ready: completes normally in both builds
    cyc("w15_idle", 0,1,2'b01,0, {E_NONE,3'd0,1'b0,1'b0,1'b0});
    cyc("w15_t0",   0,0,2'b01,0, {E_T0  ,3'd0,1'b1,1'b0,1'b0});
    for (int k = 0; k < 15; k++)
      cyc($sformatf("w15_t1_%0d", k), 0,0,2'b01,0, {E_T1,3'd1,1'b1,1'b0,1'b0});
    cyc("w15_t1_rdy", 0,0,2'b01,1, {E_T1  ,3'd1,1'b1,1'b0,1'b0});
    cyc("w15_t2",     0,0,2'b01,1, {E_T2  ,3'd2,1'b1,1'b0,1'b0});
    cyc("w15_t3",     0,0,2'b01,1, {E_T3B ,3'd3,1'b1,1'b0,1'b0});
    cyc("w15_t4",     0,0,2'b01,1, {E_T4  ,3'd4,1'b1,1'b0,1'b0});
    cyc("w15_t5",     0,0,2'b01,1, {E_T5I ,3'd5,1'b1,1'b0,1'b0});
    cyc("w15_done",   0,0,2'b01,1, {E_NONE,3'd0,1'b0,1'b1,1'b0});

    // mem_ready stuck low for 16 cycles in T1
    cyc("w16_idle", 0,1,2'b00,0, {E_NONE,3'd0,1'b0,1'b0,1'b0});
    cyc("w16_t0",   0,0,2'b00,0, {E_T0  ,3'd0,1'b1,1'b0,1'b0});
    for (int k = 0; k < 16; k++)
      cyc($sformatf("w16_t1_%0d", k), 0,0,2'b00,0, {E_T1,3'd1,1'b1,1'b0,1'b0});
`ifdef SEQ_MEM_TIMEOUT_EN
    for (int k = 0; k < 3; k++)
      cyc($sformatf("fault_%0d", k), 0,1,2'b01,1, {E_NONE,3'd0,1'b0,1'b0,1'b1});
    cyc("fault_rst", 1,0,2'b00,0, {E_NONE,3'd0,1'b0,1'b0,1'b1});
`else
    for (int k = 0; k < 3; k++)
      cyc($sformatf("hold_%0d", k), 0,0,2'b00,0, {E_T1,3'd1,1'b1,1'b0,1'b0});
    cyc("hold_rst", 1,0,2'b00,0, {E_T1,3'd1,1'b1,1'b0,1'b0});
`endif
    cyc("post_rst_idle", 0,0,2'b00,1, {E_NONE,3'd0,1'b0,1'b0,1'b0});
    cyc("post_rst_stay", 0,0,2'b00,1, {E_NONE,3'd0,1'b0,1'b0,1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldst_control_seq.md
# ldst_control_seq

Hardwired control-step sequencer for the CPU datapath. It drives the datapath strobes that fetch an instruction and execute one of four memory and immediate instruction classes: ld, ldi, st and addi. It generalises the fixed T0–T7 store sequence into an operation-selected step machine with a memory-ready handshake. It sits between the instruction-class decode and the `CPU` datapath control inputs, and replaces bench-driven strobe sequencing.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles in a memory state before fault; used only with the timeout feature.
- `TMO_W`, default 4: width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  request to begin an instruction; sampled in IDLE and DONE.
- `op`  in  2  instruction class, sampled with an accepted `start`: 00 ld, 01 ldi, 10 st, 11 addi.
- `mem_ready`  in  1  memory completed the current read or write this cycle.
- `IncPC`, `PCin`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`  out  1 each  fetch and memory strobes.
- `Gra`, `Grb`, `Rin`, `Rout`, `BAout`, `Yin`, `Cout`, `ADD`, `Zin`, `Zlowout`, `write_mem`  out  1 each  register-select and ALU strobes.
- `busy`  out  1  high in T0–T7.
- `step`  out  3  current T index; 0 when not busy.
- `done`  out  1  one-cycle pulse in DONE.
- `fault`  out  1  memory timeout; sticky until reset.

## Operation
- Moore machine: all strobes decode from the state register only.
- Reset value: every output is 0, state = IDLE, latched op = 00, wait counter = 0.

States and asserted strobes:
- IDLE: no strobes. If `start` is high, latch `op` and go to T0.
- T0: `IncPC`, `PCin`, `MARin`.
- T1: `Read`, `MDRin`. This is a wait state; it advances only when `mem_ready` is high.
- T2: `MDRout`, `IRin`.
- T3: `Grb`, `Yin`, plus `Rout` if op = addi, otherwise `BAout`.
- T4: `Cout`, `ADD`, `Zin`.
- T5:
  - ldi/addi: `Zlowout`, `Gra`, `Rin`, then go to DONE.
  - ld/st: `Zlowout`, `MARin`, then go to T6.
- T6:
  - ld: `Read`, `MDRin`. Wait state.
  - st: `Gra`, `Rout`, `MDRin`.
- T7:
  - ld: `MDRout`, `Gra`, `Rin`.
  - st: `write_mem`. Wait state.
  - Then go to DONE.
- DONE: `done` = 1. Go to T0 with a fresh `op` latch if `start` is high, otherwise go to IDLE.
- FAULT: all strobes 0, `fault` = 1. Exit only by reset.

Boundary rules:
- Wait states are T1, ld-T6 and st-T7. Their strobes stay asserted for every cycle spent in the state.
- `start` while busy is ignored.
- `op` changes after acceptance have no effect.
- `reset` has priority over everything, including mid-instruction and FAULT. The next cycle is IDLE with all outputs 0.
- `mem_ready` outside a wait state is ignored.

## Timing
- Latency from `start` high in IDLE (cycle N) with `mem_ready` tied high:
  - T0 occurs at N+1.
  - ldi/addi: DONE at N+7, 7 cycles total.
  - ld/st: DONE at N+9.
- Each cycle of `mem_ready` low in a wait state adds exactly one cycle.
- Back-to-back: `start` held high through DONE gives T0 on the cycle right after DONE, with no IDLE cycle.
- Wait counter: clears on entry to every state. It increments on each wait-state cycle with `mem_ready` low, and saturates at MEM_TIMEOUT.

## Configuration
- Macro: `SEQ_MEM_TIMEOUT_EN`.
- Defined: in a wait state, once the counter equals MEM_TIMEOUT and `mem_ready` is still low, the next state is FAULT. A wait of exactly MEM_TIMEOUT cycles that is followed by `mem_ready` high still advances normally.
- Undefined: wait states hold indefinitely, FAULT is unreachable, `fault` is tied 0, the counter is not built, and MEM_TIMEOUT/TMO_W are unused.

## Test plan
- Reset, then ldi (op=01) with `start` pulsed at cycle N and `mem_ready`=1 → T3 asserts `BAout`; T5 asserts `Zlowout`/`Gra`/`Rin`; `done` is high at N+7 only; `step` sequence reads 0,1,2,3,4,5.
- st (op=10) with `mem_ready` low for 3 cycles in T7 → `write_mem` is high for 4 consecutive cycles; `done` is at N+12; T6 asserts `Gra`/`Rout`/`MDRin`.
- ld (op=00) with 2 wait cycles in T1 and 1 in T6 → `Read` is high for 3 cycles, then for 2 cycles; T7 asserts `MDRout`/`Gra`/`Rin`; `done` is at N+12.
- addi then ldi back-to-back with `start` held → T0 follows DONE directly; T3 asserts `Rout` for the first instruction and `BAout` for the second.
- With `SEQ_MEM_TIMEOUT_EN`, MEM_TIMEOUT=15, `mem_ready` stuck low in T1 → after 16 cycles in T1, `fault`=1 with all strobes 0 until reset; a 15-cycle wait followed by `mem_ready` high completes normally.
- `reset` asserted during ld-T6 → next cycle is IDLE with all outputs 0; a subsequent `start` runs a clean full sequence.
